// File: rtl/traffic_phase_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_phase_ctrl_if
//  Purpose  : Detector inputs and lamp/phase outputs of the intersection
//             controller, bundled for connection to the lamp-driver side.
//  Revision : 1.0  initial release
// ============================================================================
interface traffic_phase_ctrl_if;
    logic       NS_VEHICLE_DETECT;
    logic       EW_VEHICLE_DETECT;
    logic       NS_RED;
    logic       NS_YELLOW;
    logic       NS_GREEN;
    logic       EW_RED;
    logic       EW_YELLOW;
    logic       EW_GREEN;
    logic [2:0] PHASE;

    modport master (
        output NS_VEHICLE_DETECT, EW_VEHICLE_DETECT,
        input  NS_RED, NS_YELLOW, NS_GREEN,
        input  EW_RED, EW_YELLOW, EW_GREEN,
        input  PHASE
    );

    modport slave (
        input  NS_VEHICLE_DETECT, EW_VEHICLE_DETECT,
        output NS_RED, NS_YELLOW, NS_GREEN,
        output EW_RED, EW_YELLOW, EW_GREEN,
        output PHASE
    );
endinterface
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_phase_ctrl
//  Purpose  : Vehicle-actuated NS/EW signal controller with tick prescaler,
//             per-phase tick timer and registered lamp outputs.
//             Optional all-red clearance phases: define TRAFFIC_ALL_RED_EN.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_phase_ctrl #(
    parameter int TICK_DIV     = 4,
    parameter int CNT_W        = 5,
    parameter int NS_MIN_GREEN = 3,
    parameter int NS_MAX_GREEN = 6,
    parameter int EW_MIN_GREEN = 2,
    parameter int EW_MAX_GREEN = 4,
    parameter int YELLOW_TIME  = 2,
    parameter int ALL_RED_TIME = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    traffic_phase_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_NS_G   = 3'd0,
        S_NS_Y   = 3'd1,
        S_NS_CLR = 3'd2,
        S_EW_G   = 3'd3,
        S_EW_Y   = 3'd4,
        S_EW_CLR = 3'd5
    } state_t;

    localparam int                   c_PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]     c_NS_MIN     = CNT_W'(NS_MIN_GREEN);
    localparam logic [CNT_W-1:0]     c_NS_MAX     = CNT_W'(NS_MAX_GREEN);
    localparam logic [CNT_W-1:0]     c_EW_MIN     = CNT_W'(EW_MIN_GREEN);
    localparam logic [CNT_W-1:0]     c_EW_MAX     = CNT_W'(EW_MAX_GREEN);
    localparam logic [CNT_W-1:0]     c_YELLOW     = CNT_W'(YELLOW_TIME);

`ifdef TRAFFIC_ALL_RED_EN
    localparam logic [CNT_W-1:0]     c_ALL_RED    = CNT_W'(ALL_RED_TIME);
    localparam state_t               c_RESET_ST   = S_EW_CLR;
    localparam state_t               c_AFTER_NS_Y = S_NS_CLR;
    localparam state_t               c_AFTER_EW_Y = S_EW_CLR;
`else
    localparam state_t               c_RESET_ST   = S_NS_G;
    localparam state_t               c_AFTER_NS_Y = S_EW_G;
    localparam state_t               c_AFTER_EW_Y = S_NS_G;
    wire logic w_unused_all_red = (ALL_RED_TIME != 0);
`endif

    state_t               r_state;
    logic [c_PRESC_W-1:0] r_presc;
    logic [CNT_W-1:0]     r_ticks;
    logic                 r_req_ns;
    logic                 r_req_ew;
    logic [5:0]           r_lamps;

    state_t               w_state_nxt;
    logic                 w_wrap;
    logic [CNT_W-1:0]     w_ticks_nxt;
    logic                 w_ns_exit;
    logic                 w_ew_exit;
    logic                 w_yel_done;
    logic                 w_req_ns_nxt;
    logic                 w_req_ew_nxt;

    // Decisions use the tick count as it will stand after this edge, so a
    // phase of N ticks occupies exactly N*TICK_DIV cycles.
    assign w_wrap      = (r_presc == c_PRESC_LAST);
    assign w_ticks_nxt = (w_wrap && (r_ticks != {CNT_W{1'b1}})) ? r_ticks + CNT_W'(1) : r_ticks;

    assign w_ns_exit  = (w_ticks_nxt >= c_NS_MIN) && r_req_ew &&
                        (!bus.NS_VEHICLE_DETECT || (w_ticks_nxt >= c_NS_MAX));
    assign w_ew_exit  = (w_ticks_nxt >= c_EW_MIN) && r_req_ns &&
                        (!bus.EW_VEHICLE_DETECT || (w_ticks_nxt >= c_EW_MAX));
    assign w_yel_done = (w_ticks_nxt == c_YELLOW);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_NS_G:   if (w_ns_exit)  w_state_nxt = S_NS_Y;
            S_NS_Y:   if (w_yel_done) w_state_nxt = c_AFTER_NS_Y;
            S_EW_G:   if (w_ew_exit)  w_state_nxt = S_EW_Y;
            S_EW_Y:   if (w_yel_done) w_state_nxt = c_AFTER_EW_Y;
`ifdef TRAFFIC_ALL_RED_EN
            S_NS_CLR: if (w_ticks_nxt == c_ALL_RED) w_state_nxt = S_EW_G;
            S_EW_CLR: if (w_ticks_nxt == c_ALL_RED) w_state_nxt = S_NS_G;
`endif
            default:  w_state_nxt = c_RESET_ST;
        endcase
    end

    // Entering a road's green clears its request even if its detector is high.
    assign w_req_ns_nxt = ((w_state_nxt == S_NS_G) && (r_state != S_NS_G)) ? 1'b0 :
                          (r_req_ns || (bus.NS_VEHICLE_DETECT && (r_state != S_NS_G)));
    assign w_req_ew_nxt = ((w_state_nxt == S_EW_G) && (r_state != S_EW_G)) ? 1'b0 :
                          (r_req_ew || (bus.EW_VEHICLE_DETECT && (r_state != S_EW_G)));

    // Lamp order: {NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN}
    function automatic logic [5:0] f_lamps(input state_t s);
        case (s)
            S_NS_G:  f_lamps = 6'b001_100;
            S_NS_Y:  f_lamps = 6'b010_100;
            S_EW_G:  f_lamps = 6'b100_001;
            S_EW_Y:  f_lamps = 6'b100_010;
            default: f_lamps = 6'b100_100;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_RESET_ST;
            r_lamps  <= f_lamps(c_RESET_ST);
            r_presc  <= '0;
            r_ticks  <= '0;
            r_req_ns <= 1'b0;
            r_req_ew <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lamps  <= f_lamps(w_state_nxt);
            r_req_ns <= w_req_ns_nxt;
            r_req_ew <= w_req_ew_nxt;
            if (w_state_nxt != r_state) begin
                r_presc <= '0;
                r_ticks <= '0;
            end else begin
                r_presc <= w_wrap ? '0 : r_presc + c_PRESC_W'(1);
                r_ticks <= w_ticks_nxt;
            end
        end
    end

    assign bus.NS_RED    = r_lamps[5];
    assign bus.NS_YELLOW = r_lamps[4];
    assign bus.NS_GREEN  = r_lamps[3];
    assign bus.EW_RED    = r_lamps[2];
    assign bus.EW_YELLOW = r_lamps[1];
    assign bus.EW_GREEN  = r_lamps[0];
    assign bus.PHASE     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_phase_ctrl
//  Purpose  : Self-checking bench for traffic_phase_ctrl: cycle-level phase
//             model plus directed scenarios with hand-computed durations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_phase_ctrl;

    localparam int TICK_DIV = 4;
    localparam int NS_MIN   = 3;
    localparam int NS_MAX   = 6;
    localparam int EW_MIN   = 2;
    localparam int EW_MAX   = 4;
    localparam int YEL      = 2;
    localparam int ALL_RED  = 1;
`ifdef TRAFFIC_ALL_RED_EN
    localparam bit CLR_EN   = 1'b1;
`else
    localparam bit CLR_EN   = 1'b0;
`endif
    localparam int RST_PHASE = CLR_EN ? 5 : 0;
    localparam int CLR_CYC   = CLR_EN ? 4 : 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    traffic_phase_ctrl_if bus();

    traffic_phase_ctrl #(
        .TICK_DIV(TICK_DIV), .CNT_W(5),
        .NS_MIN_GREEN(NS_MIN), .NS_MAX_GREEN(NS_MAX),
        .EW_MIN_GREEN(EW_MIN), .EW_MAX_GREEN(EW_MAX),
        .YELLOW_TIME(YEL), .ALL_RED_TIME(ALL_RED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: phase code, cycles already spent in the phase, requests.
    int m_phase  = 0;
    int m_cyc    = 0;
    int m_held   = 0;
    int m_nxt    = 0;
    bit m_req_ns = 1'b0;
    bit m_req_ew = 1'b0;
    bit m_valid  = 1'b0;

    function automatic logic [5:0] exp_lamps(input int p);
        case (p)
            0:       return 6'b001_100;
            1:       return 6'b010_100;
            3:       return 6'b100_001;
            4:       return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    function automatic logic [5:0] dut_lamps();
        return {bus.NS_RED, bus.NS_YELLOW, bus.NS_GREEN,
                bus.EW_RED, bus.EW_YELLOW, bus.EW_GREEN};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase  = RST_PHASE;
            m_cyc    = 0;
            m_req_ns = 1'b0;
            m_req_ew = 1'b0;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            m_held = m_cyc + 1;
            m_nxt  = m_phase;
            case (m_phase)
                0: if (m_held >= NS_MIN*TICK_DIV && m_req_ew &&
                       (!bus.NS_VEHICLE_DETECT || m_held >= NS_MAX*TICK_DIV)) m_nxt = 1;
                1: if (m_held == YEL*TICK_DIV) m_nxt = CLR_EN ? 2 : 3;
                2: if (m_held == ALL_RED*TICK_DIV) m_nxt = 3;
                3: if (m_held >= EW_MIN*TICK_DIV && m_req_ns &&
                       (!bus.EW_VEHICLE_DETECT || m_held >= EW_MAX*TICK_DIV)) m_nxt = 4;
                4: if (m_held == YEL*TICK_DIV) m_nxt = CLR_EN ? 5 : 0;
                default: if (m_held == ALL_RED*TICK_DIV) m_nxt = 0;
            endcase
            if (m_phase != 0 && bus.NS_VEHICLE_DETECT) m_req_ns = 1'b1;
            if (m_phase != 3 && bus.EW_VEHICLE_DETECT) m_req_ew = 1'b1;
            if (m_nxt == 0 && m_phase != 0) m_req_ns = 1'b0;
            if (m_nxt == 3 && m_phase != 3) m_req_ew = 1'b0;
            m_cyc   = (m_nxt != m_phase) ? 0 : m_held;
            m_phase = m_nxt;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            vectors++;
            if (bus.PHASE !== 3'(m_phase) || dut_lamps() !== exp_lamps(m_phase)) begin
                miscompares++;
                $display("FAIL model t=%0t: phase/lamps got %0d/%b expected %0d/%b",
                         $time, bus.PHASE, dut_lamps(), m_phase, exp_lamps(m_phase));
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Cycles the DUT stays in phase p, counted from the current negedge.
    task automatic dwell(input int p, output int n);
        n = 0;
        while (bus.PHASE == 3'(p) && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        bus.NS_VEHICLE_DETECT = 1'b0;
        bus.EW_VEHICLE_DETECT = 1'b0;

        // Reset state and quiet-road rest in NS green
        rst = 1'b1;
        cyc(3);
        check("reset_phase", bus.PHASE, RST_PHASE);
        check("reset_lamps", dut_lamps(), CLR_EN ? 6'b100_100 : 6'b001_100);
        rst = 1'b0;
        dwell(5, n);
        check("clr_after_reset_cycles", n, CLR_CYC);
        check("ns_green_after_reset", dut_lamps(), 6'b001_100);
        cyc(200);
        check("ns_rest_200", bus.PHASE, 0);

        // EW pulse at tick 5 of NS green with NS detector low
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        dwell(5, n);
        cyc(20);
        bus.EW_VEHICLE_DETECT = 1'b1;
        cyc(1);
        bus.EW_VEHICLE_DETECT = 1'b0;
        check("ns_g_on_pulse_edge", bus.PHASE, 0);
        cyc(1);
        check("ns_yellow_next_edge", dut_lamps(), 6'b010_100);
        // EW detector held through the EW_G entry edge: request must not survive
        bus.EW_VEHICLE_DETECT = 1'b1;
        dwell(1, n);
        check("ns_yellow_cycles", n, 8);
        dwell(2, n);
        check("ns_clr_cycles", n, CLR_CYC);
        check("ew_green_after_clear", dut_lamps(), 6'b100_001);
        bus.EW_VEHICLE_DETECT = 1'b0;
        cyc(40);
        check("ew_rest_beyond_max", bus.PHASE, 3);

        // NS pulse ends EW green; NS green must rest since EW request was dropped
        bus.NS_VEHICLE_DETECT = 1'b1;
        cyc(1);
        bus.NS_VEHICLE_DETECT = 1'b0;
        cyc(1);
        check("ew_yellow_entry", bus.PHASE, 4);
        dwell(4, n);
        check("ew_yellow_cycles", n, 8);
        dwell(5, n);
        check("ew_clr_cycles", n, CLR_CYC);
        check("ns_green_entry", bus.PHASE, 0);
        cyc(60);
        check("ew_req_not_retained", bus.PHASE, 0);

        // Both detectors busy: greens forced out by their max timers
        bus.NS_VEHICLE_DETECT = 1'b1;
        bus.EW_VEHICLE_DETECT = 1'b1;
        cyc(1);
        bus.EW_VEHICLE_DETECT = 1'b0;
        cyc(1);
        check("ns_yellow_saturated", bus.PHASE, 1);
        bus.EW_VEHICLE_DETECT = 1'b1;
        dwell(1, n);
        dwell(2, n);
        dwell(3, n);
        check("ew_max_forced_cycles", n, 16);
        dwell(4, n);
        dwell(5, n);
        bus.EW_VEHICLE_DETECT = 1'b0;
        dwell(0, n);
        check("ns_max_forced_cycles", n, 24);
        check("ns_yellow_after_max", bus.PHASE, 1);

        // Reset pulse in NS yellow with a pending EW request
        bus.EW_VEHICLE_DETECT = 1'b1;
        cyc(1);
        bus.EW_VEHICLE_DETECT = 1'b0;
        bus.NS_VEHICLE_DETECT = 1'b0;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rst_mid_yellow_phase", bus.PHASE, RST_PHASE);
        check("rst_mid_yellow_lamps", dut_lamps(), CLR_EN ? 6'b100_100 : 6'b001_100);
        dwell(5, n);
        cyc(40);
        check("req_cleared_by_rst", bus.PHASE, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

- Self-timed, vehicle-actuated controller for a two-road (NS/EW) intersection. Replaces the external nsCounter/ewCounter/yellowCounter trio plus the combinational Traffic core with one clocked block.
- Integrates a tick prescaler, a per-phase timer and a phase state machine.
- Min/max green, yellow and all-red durations are parameters.
- Drives the six lamp outputs directly; sits between the vehicle-detector inputs and the lamp drivers.

## Interface
Parameters:
- TICK_DIV, 4: clock cycles per timing tick (≥1).
- CNT_W, 5: phase tick-counter width; every time parameter < 2^CNT_W.
- NS_MIN_GREEN, 3: NS green minimum, ticks.
- NS_MAX_GREEN, 6: NS green maximum when the opposing road is waiting, ticks (≥ NS_MIN_GREEN).
- EW_MIN_GREEN, 2: EW green minimum, ticks.
- EW_MAX_GREEN, 4: EW green maximum when the opposing road is waiting, ticks (≥ EW_MIN_GREEN).
- YELLOW_TIME, 2: yellow duration, ticks (≥1).
- ALL_RED_TIME, 1: all-red clearance duration, ticks (≥1; used only with the macro).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- NS_VEHICLE_DETECT  in  1  NS detector, level, synchronous to clk.
- EW_VEHICLE_DETECT  in  1  EW detector, level, synchronous to clk.
- NS_RED, NS_YELLOW, NS_GREEN  out  1 each  NS lamps, registered.
- EW_RED, EW_YELLOW, EW_GREEN  out  1 each  EW lamps, registered.
- PHASE  out  3  current state: 0 NS_G, 1 NS_Y, 2 NS_CLR, 3 EW_G, 4 EW_Y, 5 EW_CLR.

## Operation
- States and transitions:
  - NS_G→NS_Y→NS_CLR→EW_G→EW_Y→EW_CLR→NS_G.
  - CLR states exist only with the macro; without it, Y goes directly to the opposing G.
- Lamps are decoded from the state register:
  - Exactly one lamp is lit per road.
  - The non-served road shows RED.
  - In CLR states both roads show RED.
- Prescaler and tick counter:
  - Both clear on every state entry.
  - The prescaler counts 0..TICK_DIV-1. On wrap, the tick counter increments, saturating at 2^CNT_W-1.
- Request latches (one per road):
  - Set when that road's detector is sampled high while the road is not in its G state.
  - Cleared on the cycle the road enters G. Clear wins over a simultaneous set.
- Green exit: leave X_G once ticks ≥ X_MIN_GREEN, the opposing request is set, and either:
  - own detector is low, or
  - ticks ≥ X_MAX_GREEN.
- No opposing request means rest in green indefinitely; the max timer is not enforced.
- Y exits when ticks = YELLOW_TIME. CLR exits when ticks = ALL_RED_TIME.
- Reset:
  - rst overrides everything, including mid-phase.
  - Request latches clear, prescaler clears, tick counter clears.
  - State goes to EW_CLR with the macro, or NS_G without it.

## Timing
- Reset values with the macro: PHASE=5; NS_RED=EW_RED=1; all other lamps 0.
- Reset values without the macro: PHASE=0; NS_GREEN=EW_RED=1; all other lamps 0.
- Lamps and PHASE change on the same edge as the state register. Lamp latency from the state decision is zero cycles.
- A detector sampled at edge k sets its request at edge k. The earliest green-exit edge is k+1.
- Phase durations in cycles:
  - Y lasts YELLOW_TIME×TICK_DIV.
  - CLR lasts ALL_RED_TIME×TICK_DIV.
  - G lasts at least MIN×TICK_DIV; when forced by max, exactly MAX×TICK_DIV.
- Detectors are assumed already synchronised; there is no internal synchroniser.

## Configuration
- TRAFFIC_ALL_RED_EN defined:
  - NS_CLR/EW_CLR states are present, each lasting ALL_RED_TIME ticks.
  - Reset enters EW_CLR.
- TRAFFIC_ALL_RED_EN undefined:
  - CLR states are removed; PHASE never shows 2 or 5.
  - ALL_RED_TIME is ignored.
  - Reset enters NS_G.

## Test plan
Defaults as listed above; macro defined unless stated.
- Reset release, both detectors 0:
  - PHASE=5 with all RED for 4 cycles.
  - Then NS_GREEN=1, EW_RED=1, held for ≥200 cycles with no transition.
- In NS_G at tick 5 with NS_VEHICLE_DETECT=0, pulse EW_VEHICLE_DETECT for 1 cycle:
  - NS_YELLOW on the next edge, for exactly 8 cycles.
  - Then all RED for 4 cycles, then EW_GREEN.
- NS detector held 1, EW request set on entry to NS_G: NS_GREEN lasts exactly 24 cycles, then NS_YELLOW.
- EW detector high on the edge EW_G is entered, NS detector 0:
  - The EW request is not retained.
  - EW_G rests beyond EW_MAX (16 cycles) with no transition.
- Assert rst for 1 cycle during NS_Y: next cycle PHASE=5, all RED, and request latches clear.
- Macro undefined:
  - Reset gives NS_GREEN.
  - After NS_Y (8 cycles), EW_GREEN is asserted on the very next edge.
  - PHASE never equals 2 or 5.
